// File: rtl/booth_multiply.sv
// Iterative 32x32 signed multiplier with radix-4 Booth recoding: 16 steps, two bits per step.
// A level-driven begin/end handshake gives exactly one multiply per mult_begin assertion.
module booth_multiply (
  input  logic        clk,
  input  logic        reset,
  input  logic        mult_begin,
  input  logic [31:0] mult_op1,
  input  logic [31:0] mult_op2,
  output logic [63:0] product,
  output logic        mult_end,
  output logic        busy
);

  localparam int DATA_W = 32;
  localparam int ACC_W  = DATA_W + 2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state, state_nxt;
  logic [3:0]               iter;
  logic signed [ACC_W-1:0]  x_q;
  logic [2*DATA_W+2:0]      p_q;
  logic signed [ACC_W-1:0]  a_sum;
  logic [2*DATA_W+2:0]      p_step;
  logic                     load, step, wr;

  function automatic logic signed [ACC_W-1:0] booth_term(
    input logic [2:0]              trip,
    input logic signed [ACC_W-1:0] x
  );
    case (trip)
      3'b001, 3'b010: booth_term = x;
      3'b011:         booth_term = x <<< 1;
      3'b100:         booth_term = -(x <<< 1);
      3'b101, 3'b110: booth_term = -x;
      default:        booth_term = '0;
    endcase
  endfunction

  // One Booth step: accumulate into A, then shift the whole P register right by two.
  always_comb begin
    a_sum  = $signed(p_q[2*DATA_W+2:DATA_W+1]) + booth_term(p_q[2:0], x_q);
    p_step = {{2{a_sum[ACC_W-1]}}, a_sum, p_q[DATA_W:2]};
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    wr        = 1'b0;
    case (state)
      IDLE: begin
        if (mult_begin) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!mult_begin) begin
          state_nxt = IDLE;
        end else begin
          step = 1'b1;
          if (iter == 4'd15) begin
            wr        = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (!mult_begin) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      iter    <= 4'd0;
      product <= 64'h0;
    end else begin
      state <= state_nxt;
      if (load)      iter <= 4'd0;
      else if (step) iter <= iter + 4'd1;
      if (wr)        product <= p_step[2*DATA_W:1];
    end
  end

  // Operand/partial-product registers carry no reset; they are always reloaded on start.
  always_ff @(posedge clk) begin
    if (load) begin
      x_q <= {{2{mult_op1[DATA_W-1]}}, mult_op1};
      p_q <= {{ACC_W{1'b0}}, mult_op2, 1'b0};
    end else if (step) begin
      p_q <= p_step;
    end
  end

  assign busy     = (state == RUN);
  assign mult_end = (state == DONE);

endmodule
